// File: rtl/toggle_burst_sched_pkg.sv
// Purpose: shared types and helpers for the toggle burst scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package toggle_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/toggle_burst_sched_if.sv
// Purpose: request/grant/toggle bundle between requesters and the scheduler.
// Latency: n/a (wires only).
// Backpressure: requesters hold i_req until o_gnt; the scheduler never stalls.
// Ports: i_req/i_len driven by the master (requester side); o_gnt, o_done,
//        o_busy, o_out driven by the slave (scheduler).
interface toggle_burst_sched_if #(
  parameter int K_NOUT = 4,
  parameter int K_LENW = 8
);
  logic [K_NOUT-1:0]        i_req;
  logic [K_NOUT*K_LENW-1:0] i_len;
  logic [K_NOUT-1:0]        o_gnt;
  logic [K_NOUT-1:0]        o_done;
  logic                     o_busy;
  logic [K_NOUT-1:0]        o_out;

  modport master (
    output i_req, i_len,
    input  o_gnt, o_done, o_busy, o_out
  );

  modport slave (
    input  i_req, i_len,
    output o_gnt, o_done, o_busy, o_out
  );
endinterface

// File: rtl/toggle_burst_sched_rr_arbiter.sv
// Purpose: combinational round-robin pick, searching upward from ptr+1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent decides when the pick is consumed.
// Ports: req (request vector), ptr (last winner), win (one-hot winner),
//        win_idx (winner index), any (at least one request present).
module rr_arbiter
  import toggle_sched_pkg::*;
#(
  parameter int K_NOUT = 4,
  localparam int IW = clog2_min1(K_NOUT)
) (
  input  logic [K_NOUT-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [K_NOUT-1:0] win,
  output logic [IW-1:0]     win_idx,
  output logic              any
);

  // The last winner is visited last (off == K_NOUT), giving it lowest priority.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int off = 1; off <= K_NOUT; off++) begin
      automatic int c = (int'(ptr) + off) % K_NOUT;
      if (!any && req[c]) begin
        any     = 1'b1;
        win[c]  = 1'b1;
        win_idx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/toggle_burst_sched.sv
// Purpose: shares one divider/counter engine across K_NOUT toggle channels.
// Latency: grant 1 cycle after request; toggle n at grant+n*K_DIV; done with last toggle.
// Backpressure: one burst at a time; requests seen during RUN/DONE wait for IDLE.
// Ports: i_clk, i_rst_n (async active-low); bus (slave): i_req, i_len in,
//        o_gnt, o_done, o_busy, o_out out (all outputs registered).
module toggle_burst_sched
  import toggle_sched_pkg::*;
#(
  parameter int K_NOUT = 4,
  parameter int K_LENW = 8,
  parameter int K_DIV  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  toggle_burst_sched_if.slave bus
);

  localparam int IW = clog2_min1(K_NOUT);
  localparam int DW = clog2_min1(K_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(K_DIV - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(K_NOUT - 1);

  state_t              state;
  logic [IW-1:0]       sel;
  logic [IW-1:0]       ptr;
  logic [K_LENW-1:0]   rem;
  logic [DW-1:0]       div;
  logic [K_NOUT-1:0]   out_q;
  logic [K_NOUT-1:0]   gnt_q;
  logic [K_NOUT-1:0]   done_q;
  logic                busy_q;

  logic [K_NOUT-1:0]   win;
  logic [IW-1:0]       win_idx;
  logic                win_any;
  logic [K_LENW-1:0]   win_len;
  logic [K_NOUT-1:0]   sel_bit;

  rr_arbiter #(
    .K_NOUT (K_NOUT)
  ) u_arb (
    .req     (bus.i_req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  assign win_len = bus.i_len[win_idx*K_LENW +: K_LENW];
  assign sel_bit = K_NOUT'(1) << sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      ptr    <= PTR_RST;
      rem    <= '0;
      div    <= '0;
      out_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      // Grant and done are single-cycle pulses.
      gnt_q  <= '0;
      done_q <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            sel    <= win_idx;
            ptr    <= win_idx;
            rem    <= win_len;
            div    <= '0;
            gnt_q  <= win;
            busy_q <= 1'b1;
            if (win_len == '0) begin
              // Empty burst: grant and done share the same cycle.
              done_q <= win;
              state  <= DONE;
            end else begin
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            out_q <= out_q ^ sel_bit;
            rem   <= rem - 1'b1;
            if (rem == K_LENW'(1)) begin
              done_q <= sel_bit;
              state  <= DONE;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt  = gnt_q;
  assign bus.o_done = done_q;
  assign bus.o_busy = busy_q;
  assign bus.o_out  = out_q;

endmodule

// File: tb/tb_toggle_burst_sched.sv
// Purpose: checks toggle_burst_sched (K_DIV=4 and K_DIV=1 instances) against a burst-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_toggle_burst_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nvec, nerr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  toggle_burst_sched_if #(.K_NOUT(4), .K_LENW(8)) bus4 ();
  toggle_burst_sched_if #(.K_NOUT(4), .K_LENW(8)) bus1 ();

  toggle_burst_sched #(.K_NOUT(4), .K_LENW(8), .K_DIV(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  toggle_burst_sched #(.K_NOUT(4), .K_LENW(8), .K_DIV(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- burst-level model ----------------
  // Each burst is described by its grant cycle g, length L and channel ch;
  // outputs for any cycle follow from arithmetic on those numbers.
  int         m_g    [2];
  int         m_len  [2];
  int         m_ch   [2];
  int         m_free [2];
  int         m_ptr  [2];
  bit         m_act  [2];
  logic [3:0] m_base [2];

  logic [3:0]  rq, e_gnt, e_done, e_out, a_gnt, a_done, a_out;
  logic        e_busy, a_busy;
  logic [31:0] ln;
  int          kd, n, w, last;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      kd     = (d == 0) ? 4 : 1;
      rq     = (d == 0) ? bus4.i_req  : bus1.i_req;
      ln     = (d == 0) ? bus4.i_len  : bus1.i_len;
      a_gnt  = (d == 0) ? bus4.o_gnt  : bus1.o_gnt;
      a_done = (d == 0) ? bus4.o_done : bus1.o_done;
      a_busy = (d == 0) ? bus4.o_busy : bus1.o_busy;
      a_out  = (d == 0) ? bus4.o_out  : bus1.o_out;
      e_gnt = '0; e_done = '0; e_busy = 1'b0; e_out = '0;
      if (!rst_n) begin
        m_act[d]  = 1'b0;
        m_free[d] = 0;
        m_ptr[d]  = 3;
        m_base[d] = '0;
      end else begin
        e_out = m_base[d];
        if (m_act[d] && cyc >= m_g[d]) begin
          last = m_g[d] + m_len[d] * kd;
          n = (cyc - m_g[d]) / kd;
          if (n > m_len[d]) n = m_len[d];
          if (n % 2 == 1) e_out = e_out ^ (4'b0001 << m_ch[d]);
          if (cyc == m_g[d]) e_gnt = 4'b0001 << m_ch[d];
          if (cyc == last)   e_done = 4'b0001 << m_ch[d];
          e_busy = (cyc <= last);
        end
      end
      chk($sformatf("dut%0d_gnt", d),  {28'd0, a_gnt},  {28'd0, e_gnt});
      chk($sformatf("dut%0d_done", d), {28'd0, a_done}, {28'd0, e_done});
      chk($sformatf("dut%0d_busy", d), {31'd0, a_busy}, {31'd0, e_busy});
      chk($sformatf("dut%0d_out", d),  {28'd0, a_out},  {28'd0, e_out});
      if (rst_n) begin
        if (m_act[d] && cyc == m_g[d] + m_len[d] * kd) begin
          if (m_len[d] % 2 == 1) m_base[d] = m_base[d] ^ (4'b0001 << m_ch[d]);
          m_act[d]  = 1'b0;
          m_free[d] = cyc + 1;
        end
        if (!m_act[d] && cyc >= m_free[d] && rq != 4'b0000) begin
          w = -1;
          for (int off = 1; off <= 4; off++)
            if (w < 0 && rq[(m_ptr[d] + off) % 4]) w = (m_ptr[d] + off) % 4;
          m_act[d] = 1'b1;
          m_ch[d]  = w;
          m_ptr[d] = w;
          m_g[d]   = cyc + 1;
          m_len[d] = int'(ln[w*8 +: 8]);
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_edge(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out4", {28'd0, bus4.o_out}, 32'd0);
    chk("rst_busy4", {31'd0, bus4.o_busy}, 32'd0);
    drive_edge();
    drive_edge(); rst_n = 1'b1;
  endtask

  int t0;

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0;
    bus4.i_req = '0; bus4.i_len = '0;
    bus1.i_req = '0; bus1.i_len = '0;
    @(negedge clk);
    chk("rst_gnt",  {28'd0, bus4.o_gnt},  32'd0);
    chk("rst_done", {28'd0, bus4.o_done}, 32'd0);
    chk("rst_busy", {31'd0, bus4.o_busy}, 32'd0);
    chk("rst_out",  {28'd0, bus4.o_out},  32'd0);
    chk("rst_out1", {28'd0, bus1.o_out},  32'd0);
    drive_edge(); rst_n = 1'b1;

    // Single burst on channel 2, len 3.
    drive_edge(); bus4.i_len = 32'h0003_0000; bus4.i_req = 4'b0100; t0 = cyc;
    at(t0 + 1);  chk("t1_gnt", {28'd0, bus4.o_gnt}, 32'h4);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 4);  chk("t1_out4",  {28'd0, bus4.o_out}, 32'h0);
    at(t0 + 5);  chk("t1_out5",  {28'd0, bus4.o_out}, 32'h4);
    at(t0 + 9);  chk("t1_out9",  {28'd0, bus4.o_out}, 32'h0);
    at(t0 + 13); chk("t1_out13", {28'd0, bus4.o_out}, 32'h4);
    chk("t1_done13", {28'd0, bus4.o_done}, 32'h4);
    chk("t1_busy13", {31'd0, bus4.o_busy}, 32'h1);
    at(t0 + 14); chk("t1_busy14", {31'd0, bus4.o_busy}, 32'h0);

    // Round robin with requesters 0,1,3 held, len 1 each.
    do_reset();
    drive_edge(); bus4.i_len = 32'h0101_0101; bus4.i_req = 4'b1011; t0 = cyc;
    at(t0 + 1);  chk("rr_g0", {28'd0, bus4.o_gnt}, 32'h1);
    at(t0 + 6);  chk("rr_gap", {28'd0, bus4.o_gnt}, 32'h0);
    at(t0 + 7);  chk("rr_g1", {28'd0, bus4.o_gnt}, 32'h2);
    at(t0 + 13); chk("rr_g3", {28'd0, bus4.o_gnt}, 32'h8);
    at(t0 + 19); chk("rr_g0b", {28'd0, bus4.o_gnt}, 32'h1);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 24); chk("rr_busy", {31'd0, bus4.o_busy}, 32'h0);
    chk("rr_out", {28'd0, bus4.o_out}, 32'hA);

    // Zero-length burst on channel 1.
    drive_edge(); bus4.i_len = '0; bus4.i_req = 4'b0010; t0 = cyc;
    at(t0 + 1);
    chk("z_gnt",  {28'd0, bus4.o_gnt},  32'h2);
    chk("z_done", {28'd0, bus4.o_done}, 32'h2);
    chk("z_out",  {28'd0, bus4.o_out},  32'hA);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 2);  chk("z_idle", {31'd0, bus4.o_busy}, 32'h0);

    // All four request right after reset.
    do_reset();
    drive_edge(); bus4.i_len = 32'h0101_0101; bus4.i_req = 4'b1111; t0 = cyc;
    at(t0 + 1);  chk("all_g0", {28'd0, bus4.o_gnt}, 32'h1);
    at(t0 + 7);  chk("all_g1", {28'd0, bus4.o_gnt}, 32'h2);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 12); chk("all_out", {28'd0, bus4.o_out}, 32'h3);

    // Reset in the middle of a len-4 burst on channel 0.
    drive_edge(); bus4.i_len = 32'h0000_0004; bus4.i_req = 4'b0001; t0 = cyc;
    at(t0 + 1);  chk("mr_gnt", {28'd0, bus4.o_gnt}, 32'h1);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 10); chk("mr_out_pre", {28'd0, bus4.o_out}, 32'h3);
    drive_edge(); rst_n = 1'b0;
    at(t0 + 11);
    chk("mr_out",  {28'd0, bus4.o_out},  32'h0);
    chk("mr_busy", {31'd0, bus4.o_busy}, 32'h0);
    chk("mr_done", {28'd0, bus4.o_done}, 32'h0);
    drive_edge();
    drive_edge(); rst_n = 1'b1; bus4.i_len = '0; bus4.i_req = 4'b1111; t0 = cyc;
    at(t0 + 1);
    chk("mr_prio", {28'd0, bus4.o_gnt},  32'h1);
    chk("mr_zd",   {28'd0, bus4.o_done}, 32'h1);
    drive_edge(); bus4.i_req = '0;
    at(t0 + 3);  chk("mr_idle", {31'd0, bus4.o_busy}, 32'h0);

    // K_DIV=1 instance, len 4 on channel 0.
    drive_edge(); bus1.i_len = 32'h0000_0004; bus1.i_req = 4'b0001; t0 = cyc;
    at(t0 + 1);  chk("d1_gnt", {28'd0, bus1.o_gnt}, 32'h1);
    chk("d1_out1", {28'd0, bus1.o_out}, 32'h0);
    drive_edge(); bus1.i_req = '0;
    at(t0 + 2);  chk("d1_out2", {28'd0, bus1.o_out}, 32'h1);
    at(t0 + 3);  chk("d1_out3", {28'd0, bus1.o_out}, 32'h0);
    at(t0 + 4);  chk("d1_out4", {28'd0, bus1.o_out}, 32'h1);
    at(t0 + 5);  chk("d1_out5", {28'd0, bus1.o_out}, 32'h0);
    chk("d1_done", {28'd0, bus1.o_done}, 32'h1);
    at(t0 + 6);  chk("d1_busy", {31'd0, bus1.o_busy}, 32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
